// File: rtl/alu_iter.sv
// Iterative RV32I/RV64I ALU: combinational arithmetic, logic, compare, branch and
// Zba shift-add; shifts advance SHIFT_STEP bits per cycle under start/done.
module alu_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1,
    parameter bit          SHADD_EN   = 1'b1,
    localparam int unsigned SW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      f3,
    input  logic            arith_bit,
    input  logic            shadd,
    input  logic            branch,
    output logic [XLEN-1:0] out,
    output logic [SW-1:0]   shamt_out,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} shop_t;

    // One extra bit so a step equal to XLEN is still representable
    localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

    state_t          state;
    shop_t           op;
    logic [XLEN-1:0] acc;
    logic [SW-1:0]   cnt;

    logic [SW-1:0]   shamt;
    logic            shadd_sel;
    logic            is_shift;
    logic            launch;
    shop_t           new_op;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic            taken;
    logic [XLEN-1:0] res;
    logic [SW-1:0]   step;
    logic [SW-1:0]   cnt_nxt;
    logic [XLEN-1:0] acc_sh;

    // Op decode: branch beats shift-add, shift-add beats plain funct3
    always_comb begin
        shamt     = src_b[SW-1:0];
        shadd_sel = SHADD_EN && shadd && (f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
        is_shift  = !branch && !shadd_sel && (f3 == 3'b001 || f3 == 3'b101);
        launch    = start && is_shift && (shamt != '0);
        new_op    = (f3 == 3'b001) ? OP_SLL : (arith_bit ? OP_SRA : OP_SRL);
        lt_s      = $signed(src_a) < $signed(src_b);
        lt_u      = src_a < src_b;
        eq        = src_a == src_b;
    end

    // Combinational result for everything except a running shift
    always_comb begin
        res   = src_a;
        taken = 1'b0;
        if (branch) begin
            case (f3)
                3'b000:  taken = eq;
                3'b001:  taken = !eq;
                3'b100:  taken = lt_s;
                3'b101:  taken = !lt_s;
                3'b110:  taken = lt_u;
                3'b111:  taken = !lt_u;
                default: taken = 1'b0;
            endcase
            res = {{(XLEN-1){1'b0}}, taken};
        end else if (shadd_sel) begin
            case (f3)
                3'b010:  res = (src_a << 1) + src_b;
                3'b100:  res = (src_a << 2) + src_b;
                default: res = (src_a << 3) + src_b;
            endcase
        end else begin
            case (f3)
                3'b000:  res = arith_bit ? (src_a - src_b) : (src_a + src_b);
                3'b010:  res = {{(XLEN-1){1'b0}}, lt_s};
                3'b011:  res = {{(XLEN-1){1'b0}}, lt_u};
                3'b100:  res = src_a ^ src_b;
                3'b110:  res = src_a | src_b;
                3'b111:  res = src_a & src_b;
                default: res = src_a;
            endcase
        end
    end

    // One shift iteration: the last step may be shorter than SHIFT_STEP
    always_comb begin
        step    = ({1'b0, cnt} < STEP_W) ? cnt : STEP_W[SW-1:0];
        cnt_nxt = cnt - step;
        case (op)
            OP_SLL:  acc_sh = acc << step;
            OP_SRA:  acc_sh = $signed(acc) >>> step;
            default: acc_sh = acc >> step;
        endcase
    end

    always_comb begin
        out       = res;
        done      = 1'b1;
        shamt_out = '0;
        case (state)
            SHIFT: begin
                out       = acc;
                done      = 1'b0;
                shamt_out = cnt;
            end
            HOLD: begin
                out  = start ? res : acc;
                done = !launch;
            end
            default: done = !launch;
        endcase
        if (rst) begin
            done      = 1'b1;
            shamt_out = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op    <= OP_SLL;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (launch) begin
                        acc   <= src_a;
                        cnt   <= shamt;
                        op    <= new_op;
                        state <= SHIFT;
                    end else if (start) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc <= acc_sh;
                    cnt <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench: three alu_iter configurations share one stimulus stream and are
// checked against an arithmetic reference model.
module tb_alu_iter;

    typedef struct {
        logic [63:0] val;
        int          k;
        int          due;
        int          sh;
        int          step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] src_a = '0;
    logic [63:0] src_b = '0;
    logic [2:0]  f3 = '0;
    logic        arith_bit = 1'b0;
    logic        shadd = 1'b0;
    logic        branch = 1'b0;

    logic [31:0] o0, o1;
    logic [63:0] o2;
    logic [4:0]  s0, s1;
    logic [5:0]  s2;
    logic        d0, d1, d2;

    logic [63:0] outv [3];
    logic [63:0] shv [3];
    logic        dn [3];

    int xl [3] = '{32, 32, 64};
    int st [3] = '{1, 4, 8};
    bit se [3] = '{1'b1, 1'b0, 1'b1};

    exp_t q [3][$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_iter #(.XLEN(32), .SHIFT_STEP(1), .SHADD_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(start), .src_a(src_a[31:0]), .src_b(src_b[31:0]),
        .f3(f3), .arith_bit(arith_bit), .shadd(shadd), .branch(branch),
        .out(o0), .shamt_out(s0), .done(d0));
    alu_iter #(.XLEN(32), .SHIFT_STEP(4), .SHADD_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .src_a(src_a[31:0]), .src_b(src_b[31:0]),
        .f3(f3), .arith_bit(arith_bit), .shadd(shadd), .branch(branch),
        .out(o1), .shamt_out(s1), .done(d1));
    alu_iter #(.XLEN(64), .SHIFT_STEP(8), .SHADD_EN(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start), .src_a(src_a), .src_b(src_b),
        .f3(f3), .arith_bit(arith_bit), .shadd(shadd), .branch(branch),
        .out(o2), .shamt_out(s2), .done(d2));

    assign outv[0] = 64'(o0);
    assign outv[1] = 64'(o1);
    assign outv[2] = o2;
    assign shv[0]  = 64'(s0);
    assign shv[1]  = 64'(s1);
    assign shv[2]  = 64'(s2);
    assign dn[0]   = d0;
    assign dn[1]   = d1;
    assign dn[2]   = d2;

    function automatic bit is_sadd(input bit sh_en, input logic [2:0] fn, input logic sa);
        return sh_en && sa && (fn == 3'd2 || fn == 3'd4 || fn == 3'd6);
    endfunction

    function automatic logic [63:0] model(input int xlen, input bit sh_en, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic [2:0] fn,
                                          input logic ar, input logic sa, input logic br);
        logic [63:0]        mask, a, b, r;
        logic signed [63:0] as_, bs;
        int                 sh;
        logic               lt, ltu;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        as_  = (xlen == 64) ? a : {{32{a[31]}}, a[31:0]};
        bs   = (xlen == 64) ? b : {{32{b[31]}}, b[31:0]};
        sh   = int'(b % 64'(xlen));
        lt   = as_ < bs;
        ltu  = a < b;
        r    = '0;
        if (br) begin
            case (fn)
                3'd0:    r = {63'd0, a == b};
                3'd1:    r = {63'd0, a != b};
                3'd4:    r = {63'd0, lt};
                3'd5:    r = {63'd0, !lt};
                3'd6:    r = {63'd0, ltu};
                3'd7:    r = {63'd0, !ltu};
                default: r = '0;
            endcase
        end else if (is_sadd(sh_en, fn, sa)) begin
            r = (a << (int'(fn) / 2)) + b;
        end else begin
            case (fn)
                3'd0: r = ar ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = {63'd0, lt};
                3'd3: r = {63'd0, ltu};
                3'd4: r = a ^ b;
                3'd5: begin
                    if (ar) r = as_ >>> sh;
                    else    r = a >> sh;
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r & mask;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, expv);
        end
    endtask

    function automatic bit all_empty();
        return q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0;
    endfunction

    // Monitor: pops an expectation whenever a DUT reports done
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                chk("rst_done", d, 64'(dn[d]), 64'd1);
                chk("rst_shamt", d, shv[d], 64'd0);
            end else if (q[d].size() != 0) begin
                e = q[d][0];
                if (dn[d]) begin
                    void'(q[d].pop_front());
                    chk("out", d, outv[d], e.val);
                    chk("latency", d, 64'(cyc), 64'(e.due));
                    chk("shamt_idle", d, shv[d], 64'd0);
                end else if (cyc > e.due) begin
                    void'(q[d].pop_front());
                    chk("done_late", d, 64'(dn[d]), 64'd1);
                end else begin
                    chk("shamt_run", d, shv[d],
                        (cyc == e.k) ? 64'd0 : 64'(e.sh - (cyc - e.k - 1) * e.step));
                end
            end
        end
    end

    task automatic issue(input logic [63:0] a_i, input logic [63:0] b_i, input logic [2:0] f_i,
                         input logic ar_i, input logic sa_i, input logic br_i);
        exp_t        e;
        logic [63:0] last [3];
        int          minl, k, lat, sh;
        bit          shift, ok;
        src_a = a_i; src_b = b_i; f3 = f_i; arith_bit = ar_i; shadd = sa_i; branch = br_i;
        start = 1'b1;
        k     = cyc;
        minl  = 1000;
        for (int d = 0; d < 3; d++) begin
            shift  = !br_i && !is_sadd(se[d], f_i, sa_i) && (f_i == 3'd1 || f_i == 3'd5);
            sh     = int'((b_i & ((64'd1 << $clog2(xl[d])) - 64'd1)));
            lat    = (shift && sh > 0) ? (sh + st[d] - 1) / st[d] : 0;
            e.val  = model(xl[d], se[d], a_i, b_i, f_i, ar_i, sa_i, br_i);
            e.k    = k;
            e.due  = (lat == 0) ? k : k + 1 + lat;
            e.sh   = sh;
            e.step = st[d];
            q[d].push_back(e);
            last[d] = e.val;
            if (lat < minl) minl = lat;
        end
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (all_empty()) begin
                ok = 1'b1;
                break;
            end
            // Extra start pulses only while every DUT is still mid-shift
            if (minl > 0 && cyc <= k + minl && $urandom_range(2) == 0) begin
                start = 1'b1;
                src_a = {$urandom, $urandom};
                src_b = {$urandom, $urandom};
                f3    = 3'($urandom_range(7));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!ok) begin
            $display("FAIL timeout waiting for done at cyc=%0d", cyc);
            $fatal(1);
        end
        // Result must stay put in HOLD while the inputs wander
        if (minl > 0) begin
            src_a  = {$urandom, $urandom};
            src_b  = {$urandom, $urandom};
            f3     = 3'($urandom_range(7));
            branch = 1'($urandom_range(1));
            for (int d = 0; d < 3; d++) begin
                e.val = last[d]; e.k = cyc; e.due = cyc; e.sh = 0; e.step = st[d];
                q[d].push_back(e);
            end
            @(posedge clk); #1;
            if (!all_empty()) begin
                $display("FAIL hold result not presented at cyc=%0d", cyc);
                $fatal(1);
            end
        end
    endtask

    task automatic reset_mid_shift();
        exp_t e;
        src_a = 64'd1; src_b = 64'd20; f3 = 3'd1; arith_bit = 1'b0; shadd = 1'b0; branch = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            e.val = 64'd1; e.k = cyc; e.due = cyc; e.sh = 0; e.step = st[d];
            q[d].push_back(e);
        end
        @(posedge clk); #1;
        if (!all_empty()) begin
            $display("FAIL idle after reset not seen at cyc=%0d", cyc);
            $fatal(1);
        end
    endtask

    initial begin
        logic [63:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(64'd5, 64'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        issue(64'd5, 64'd7, 3'd0, 1'b1, 1'b0, 1'b0);
        issue(64'd5, 64'd7, 3'd3, 1'b0, 1'b0, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        issue(64'd1, 64'd31, 3'd1, 1'b0, 1'b0, 1'b0);
        issue(64'h8000_0000, 64'd5, 3'd5, 1'b1, 1'b0, 1'b0);
        issue(64'h8000_0000, 64'd5, 3'd5, 1'b0, 1'b0, 1'b0);
        issue(64'h1234, 64'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        issue(64'h1234, 64'd32, 3'd5, 1'b1, 1'b0, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd4, 1'b0, 1'b0, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd7, 1'b0, 1'b0, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd6, 1'b0, 1'b0, 1'b1);
        issue(64'd7, 64'd7, 3'd0, 1'b0, 1'b0, 1'b1);
        issue(64'd7, 64'd7, 3'd1, 1'b0, 1'b0, 1'b1);
        issue(64'd3, 64'd10, 3'd4, 1'b0, 1'b1, 1'b0);
        issue(64'h2000_0000, 64'd1, 3'd6, 1'b0, 1'b1, 1'b0);
        issue(64'd1, 64'd63, 3'd1, 1'b0, 1'b0, 1'b0);
        issue(64'hF000_0000_8000_0001, 64'd63, 3'd5, 1'b1, 1'b0, 1'b0);

        reset_mid_shift();

        for (int i = 0; i < 150; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(1) == 1) b = 64'($urandom_range(63));
            issue(a, b, 3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(3) == 0));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised iterative ALU for the multi-cycle core datapath; successor to the fixed 32-bit, 1-bit-per-cycle ALU. Evaluates RV32I/RV64I register-register and immediate ops, branch compares and optional Zba shift-add. Non-shift ops complete combinationally. Shifts iterate `SHIFT_STEP` bits per cycle under a `start`/`done` handshake. The datapath drives it from `r1`/`r2`/`pc`/`imm`, and the control FSM stalls on `done`.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `SHIFT_STEP`, 1: bits shifted per iteration; power of 2, 1..`XLEN`.
- `SHADD_EN`, 1: 1 enables sh1add/sh2add/sh3add; 0 ignores `shadd`.
- `SW` (derived), $clog2(`XLEN`): shift-amount width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the op currently on the inputs.
- `src_a`  in  XLEN  operand A.
- `src_b`  in  XLEN  operand B; shift amount = `src_b[SW-1:0]`.
- `f3`  in  3  RISC-V funct3.
- `arith_bit`  in  1  SUB for f3=000, SRA for f3=101.
- `shadd`  in  1  Zba shift-add select.
- `branch`  in  1  branch-compare mode.
- `out`  out  XLEN  result.
- `shamt_out`  out  SW  remaining shift count.
- `done`  out  1  `out` valid, unit idle.

## Operation
- States: IDLE, SHIFT, HOLD. Internal registers: `acc` (XLEN), `cnt` (SW), `op` (SLL/SRL/SRA).
- Op decode priority: `branch` > (`shadd` && `SHADD_EN`) > `f3`.
- Branch mode: `out` = {0…, taken}.
  - f3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - f3 010/011: taken=0.
- Shadd mode: f3 010 → (a<<1)+b, 100 → (a<<2)+b, 110 → (a<<3)+b; other f3 falls through to normal decode.
- Normal decode: 000 add/sub, 010 SLT, 011 SLTU (result 0/1), 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL/SRA. Arithmetic wraps modulo 2^XLEN.
- IDLE and HOLD:
  - Non-shift op: `out` = combinational result of current inputs; `done`=1 whether or not `start` is high.
  - Shift with shamt=0: `out`=`src_a`, `done`=1.
  - `start` with a shift op and shamt≠0: `acc`←`src_a`, `cnt`←shamt, latch `op`, go to SHIFT. `done`=0 in the start cycle.
  - HOLD with `start` low: `out`=`acc` regardless of inputs. Any `start` leaves HOLD (to IDLE or SHIFT).
  - IDLE with a shift op and `start` low: `out`=`src_a`.
- SHIFT:
  - Per cycle s = min(`SHIFT_STEP`, `cnt`); `acc` shifted by s; `cnt`←`cnt`−s.
  - SRA fills with `acc[XLEN-1]`; SLL/SRL fill with 0.
  - Go to HOLD when `cnt`−s == 0.
  - `done`=0 and `out`=`acc` (partial) throughout SHIFT.
  - `start` in SHIFT is ignored; operands are not re-sampled.
- `shamt_out` = `cnt` in SHIFT; 0 in IDLE and HOLD.
- Reset: state←IDLE, `acc`←0, `cnt`←0.
  - While `rst` is high: `done`=1, `shamt_out`=0.
  - Reset mid-SHIFT aborts the op; the partial `acc` is discarded.

## Timing
- Non-shift ops, and shifts with shamt=0: zero-cycle latency, combinational `src`→`out`.
- Shift latency: `start` sampled at edge 0; `done` rises after edge ceil(shamt/`SHIFT_STEP`) with final `out`. Max ceil((XLEN−1)/SHIFT_STEP) cycles.
- `done` depends combinationally on `start`, `f3`, `branch`, `shadd`, `src_b`, plus state.
- Back-to-back: a `start` in HOLD may launch the next op the same cycle the previous result is consumed.
- `out` from HOLD is stable until the next `start`.

## Test plan
- Reset, then ADD 5+7 → `out`=12, `done`=1. SUB 5−7 → 0xFFFFFFFE. SLTU 5,7 → 1. SLT 0xFFFFFFFF,1 → 1.
- `SHIFT_STEP`=1: SLL 0x1 by 31 with one-cycle `start` → `done`=0 for 31 edges, `shamt_out` 31→1, then `out`=0x80000000 and `done`=1. `out` holds after `src_a` changes.
- `SHIFT_STEP`=4: SRA 0x80000000 by 5 → 2 cycles, `out`=0xFC000000. SRL same operands → 0x04000000. Shift by 0 → `out`=`src_a`, `done` never drops.
- Branch: BLT −1,1 → `out`=1; BGEU −1,1 → 1; BLTU −1,1 → 0; BEQ 7,7 → 1; BNE 7,7 → 0.
- `SHADD_EN`=1: sh2add a=3, b=10 → 22; sh3add a=0x20000000, b=1 → 1 (wrap). `SHADD_EN`=0: same inputs (f3=100) → XOR 3^10=9.
- Reset asserted after 3 cycles of a 20-cycle SLL → next cycle `done`=1, `shamt_out`=0, IDLE. `start` pulses during SHIFT do not change the result. XLEN=64, STEP=8: SLL 1 by 63 → 8 cycles, `out`=2^63.
